// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Brief    : Instruction-memory, instruction-queue and redirect signals of the
//            fetch stage, bundled with master (fetch side) and slave modports.
// Revision : 1.0
// ============================================================================
interface fetch_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        enqueue;
    logic [63:0] enqueue_wdata;
    logic        is_full;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_addr, imem_rmask, enqueue, enqueue_wdata,
        input  imem_rdata, imem_resp, is_full, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, imem_rmask, enqueue, enqueue_wdata,
        output imem_rdata, imem_resp, is_full, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Owns the PC, issues one imem read at a time and pushes
//            {pc, inst} entries into the instruction queue.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  wire logic clk,
    input  wire logic rst,
    fetch_if.master   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_inc;
    logic        r_stale;
    logic        w_stale_nxt;
    logic [31:0] r_hold_inst;
    logic [31:0] w_hold_nxt;
    logic [3:0]  w_rmask;
    logic        w_enqueue;
    logic [63:0] w_enqueue_wdata;

    assign w_pc_inc = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_stale     <= 1'b0;
            r_hold_inst <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_stale     <= w_stale_nxt;
            r_hold_inst <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_stale_nxt = r_stale;
        w_hold_nxt  = r_hold_inst;
        case (r_state)
            S_IDLE: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt = bus.redirect_pc;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid && !bus.imem_resp) begin
                    // Read still in flight: remember to drop its response.
                    w_pc_nxt    = bus.redirect_pc;
                    w_stale_nxt = 1'b1;
                end else if (bus.redirect_valid) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_stale_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (bus.imem_resp && r_stale) begin
                    w_stale_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (bus.imem_resp && !bus.is_full) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_IDLE;
                end else if (bus.imem_resp) begin
                    w_hold_nxt  = bus.imem_rdata;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_state_nxt = S_IDLE;
                end else if (!bus.is_full) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rmask         = 4'h0;
        w_enqueue       = 1'b0;
        w_enqueue_wdata = 64'h0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.redirect_valid) begin
                        w_rmask = 4'hF;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp && !r_stale && !bus.redirect_valid && !bus.is_full) begin
                        w_enqueue       = 1'b1;
                        w_enqueue_wdata = {r_pc, bus.imem_rdata};
                    end
                end
                S_HOLD: begin
                    if (!bus.redirect_valid && !bus.is_full) begin
                        w_enqueue       = 1'b1;
                        w_enqueue_wdata = {r_pc, r_hold_inst};
                    end
                end
                default: begin
                    w_rmask = 4'h0;
                end
            endcase
        end
    end

    assign bus.imem_addr     = r_pc;
    assign bus.imem_rmask    = w_rmask;
    assign bus.enqueue       = w_enqueue;
    assign bus.enqueue_wdata = w_enqueue_wdata;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit: directed scenarios plus random
//            traffic against a transaction-level model of the fetch stream.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h1eceb000;

    logic clk;
    logic rst;
    fetch_if bus ();

    fetch_unit #(.RESET_PC(C_RESET_PC)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model of the fetch stream: next fetch pc, read in flight (possibly
    // killed by a redirect), and a returned word parked for a full queue.
    logic [31:0] m_pc;
    logic        m_known    = 1'b0;
    logic        m_inflight = 1'b0;
    logic        m_killed   = 1'b0;
    logic        m_parked   = 1'b0;
    logic [31:0] m_word;

    // Memory responder knobs.
    int          resp_wait = 0;
    int          lat       = 1;
    logic        rand_mode = 1'b0;
    logic        stray_en  = 1'b0;
    logic [31:0] mem_data  = 32'h0;

    logic [63:0] enq_log[$];
    int          enq_cyc[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic f);
        logic        busy;
        logic [3:0]  exp_mask;
        logic        exp_en;
        logic [63:0] exp_wd;
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.is_full        = f;
        bus.imem_resp      = 1'b0;
        bus.imem_rdata     = $urandom;
        busy = m_inflight || m_parked;
        if (r) begin
            resp_wait = 0;
        end else if (resp_wait > 0) begin
            resp_wait--;
            if (resp_wait == 0) begin
                bus.imem_resp  = 1'b1;
                bus.imem_rdata = rand_mode ? $urandom : mem_data;
            end
        end else if (!busy && stray_en && $urandom_range(0, 3) == 0) begin
            bus.imem_resp = 1'b1;
        end
        #2;
        exp_mask = (!r && !busy && !rv) ? 4'hF : 4'h0;
        exp_en   = 1'b0;
        exp_wd   = 64'h0;
        if (!r && !rv && !f) begin
            if (m_inflight && bus.imem_resp && !m_killed) begin
                exp_en = 1'b1;
                exp_wd = {m_pc, bus.imem_rdata};
            end else if (m_parked) begin
                exp_en = 1'b1;
                exp_wd = {m_pc, m_word};
            end
        end
        if (m_known) check_val("imem_addr", {32'h0, bus.imem_addr}, {32'h0, m_pc});
        check_val("imem_rmask", {60'h0, bus.imem_rmask}, {60'h0, exp_mask});
        check_val("enqueue", {63'h0, bus.enqueue}, {63'h0, exp_en});
        check_val("enqueue_wdata", bus.enqueue_wdata, exp_wd);
        if (bus.enqueue === 1'b1) begin
            enq_log.push_back(bus.enqueue_wdata);
            enq_cyc.push_back(cyc);
        end
        // Advance the model to what the next cycle should look like.
        if (r) begin
            m_pc       = C_RESET_PC;
            m_known    = 1'b1;
            m_inflight = 1'b0;
            m_killed   = 1'b0;
            m_parked   = 1'b0;
        end else if (!busy) begin
            if (rv) begin
                m_pc = rp;
            end else begin
                m_inflight = 1'b1;
                m_killed   = 1'b0;
                resp_wait  = rand_mode ? $urandom_range(1, 4) : lat;
            end
        end else if (m_inflight) begin
            if (bus.imem_resp) begin
                m_inflight = 1'b0;
                if (rv) begin
                    m_pc = rp;
                end else if (!m_killed) begin
                    if (!f) begin
                        m_pc = m_pc + 32'd4;
                    end else begin
                        m_parked = 1'b1;
                        m_word   = bus.imem_rdata;
                    end
                end
            end else if (rv) begin
                m_pc     = rp;
                m_killed = 1'b1;
            end
        end else begin
            if (rv) begin
                m_pc     = rp;
                m_parked = 1'b0;
            end else if (!f) begin
                m_pc     = m_pc + 32'd4;
                m_parked = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_enq(input int n, input int budget);
        int start;
        start = enq_log.size();
        for (int i = 0; i < budget && (enq_log.size() - start) < n; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
        end
        check_val("enq_count", 64'(enq_log.size() - start), 64'(n));
    endtask

    initial begin
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.is_full        = 1'b0;
        bus.imem_resp      = 1'b0;
        bus.imem_rdata     = 32'h0;
        @(posedge clk);
        #1;

        // Reset for two cycles, then first fetch answered at k=1.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check_val("reset_addr", {32'h0, bus.imem_addr}, {32'h0, C_RESET_PC});
        lat = 1; mem_data = 32'h00000013;
        enq_log.delete(); enq_cyc.delete();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_val("first_entry", (enq_log.size() > 0) ? enq_log[0] : 64'h0, 64'h1eceb000_00000013);
        check_val("second_addr", {32'h0, bus.imem_addr}, 64'h1eceb004);

        // Streaming at k=2: one entry every three cycles, in order.
        lat = 2; mem_data = 32'h00c0ffee;
        step(1'b1, 1'b0, 32'h0, 1'b0);
        enq_log.delete(); enq_cyc.delete();
        run_until_enq(8, 100);
        for (int i = 0; i < 8 && i < enq_log.size(); i++) begin
            check_val("stream_pc", {32'h0, enq_log[i][63:32]}, {32'h0, C_RESET_PC + 32'(4 * i)});
            if (i > 0) check_val("stream_gap", 64'(enq_cyc[i] - enq_cyc[i-1]), 64'd3);
        end

        // Back-pressure: response lands on a full queue, held for 5 cycles.
        lat = 1; mem_data = 32'hdeadbeef;
        enq_log.delete(); enq_cyc.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        check_val("bp_no_enq", 64'(enq_log.size()), 64'd0);
        run_until_enq(1, 5);
        check_val("bp_word", {32'h0, (enq_log.size() > 0) ? enq_log[0][31:0] : 32'h0}, 64'hdeadbeef);

        // Redirect one cycle after issue, response at k=3 is dropped.
        lat = 3; mem_data = 32'h11111111;
        enq_log.delete(); enq_cyc.delete();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h1eceb100, 1'b0);
        run_until_enq(1, 20);
        check_val("wait_redir_pc", {32'h0, (enq_log.size() > 0) ? enq_log[0][63:32] : 32'h0}, 64'h1eceb100);

        // Redirect coincident with the response.
        lat = 2;
        enq_log.delete(); enq_cyc.delete();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h1eceb200, 1'b0);
        run_until_enq(1, 20);
        check_val("coinc_redir_pc", {32'h0, (enq_log.size() > 0) ? enq_log[0][63:32] : 32'h0}, 64'h1eceb200);

        // Redirect while a word is parked in HOLD.
        lat = 1; mem_data = 32'h22222222;
        enq_log.delete(); enq_cyc.delete();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h1eceb300, 1'b1);
        mem_data = 32'h33333333;
        run_until_enq(1, 20);
        check_val("hold_redir_pc", {32'h0, (enq_log.size() > 0) ? enq_log[0][63:32] : 32'h0}, 64'h1eceb300);
        check_val("hold_redir_word", {32'h0, (enq_log.size() > 0) ? enq_log[0][31:0] : 32'h0}, 64'h33333333);

        // Reset in the middle of a read.
        lat = 3;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check_val("midwait_rst_addr", {32'h0, bus.imem_addr}, {32'h0, C_RESET_PC});

        // PC wrap.
        lat = 1;
        enq_log.delete(); enq_cyc.delete();
        step(1'b0, 1'b1, 32'hfffffffc, 1'b0);
        run_until_enq(2, 20);
        check_val("wrap_pc0", {32'h0, (enq_log.size() > 0) ? enq_log[0][63:32] : 32'h0}, 64'hfffffffc);
        check_val("wrap_pc1", {32'h0, (enq_log.size() > 1) ? enq_log[1][63:32] : 32'h1}, 64'h0);

        // Random traffic.
        rand_mode = 1'b1;
        stray_en  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 7) == 0,
                 {$urandom_range(0, 32'h3fffffff), 2'b00},
                 $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
